pulse: RTL and testbench
========================

PULSE -- requirements
Module: pulse

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of input synchronizer flops; legal range 1 to 4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive clk edges a new synchronized level must persist before it is accepted; legal range 1 to 65535.
REQ-003 Parameter EDGE_MODE, default EDGE_RISE: which debounced transition produces a pulse; values EDGE_RISE, EDGE_FALL, EDGE_BOTH.
REQ-004 clk  input  1  single clock; all state changes on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-006 in  input  1  raw level input, possibly asynchronous to clk (e.g. pushbutton).
REQ-007 out  output  1  registered single-cycle pulse marking an accepted edge of in.

Function
REQ-008 in SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the synchronized signal s.
REQ-009 The block SHALL hold a debounced level deb and a counter cnt of width $clog2(DEBOUNCE_CYCLES)+1.
REQ-010 On each edge where s equals deb, cnt SHALL clear to 0.
REQ-011 On each edge where s differs from deb and cnt equals DEBOUNCE_CYCLES-1, deb SHALL take s and cnt SHALL clear to 0.
REQ-012 Otherwise (s differs from deb and cnt is below DEBOUNCE_CYCLES-1), cnt SHALL increment by 1; the counter never wraps.
REQ-013 A glitch on s shorter than DEBOUNCE_CYCLES edges SHALL leave deb unchanged and produce no pulse.
REQ-014 out SHALL be registered and set on the same edge deb changes, if that transition matches EDGE_MODE (0->1 for RISE, 1->0 for FALL, either for BOTH).
REQ-015 out SHALL be high for exactly one clk cycle per accepted transition, regardless of how long in remains at the new level.
REQ-016 Latency: out SHALL rise on the edge SYNC_STAGES+DEBOUNCE_CYCLES-1 edges after the first edge that samples the new in level (defaults: 5; DEBOUNCE_CYCLES=1, SYNC_STAGES=2: 2).
REQ-017 A new transition SHALL NOT be accepted until deb has settled, so back-to-back pulses are separated by at least DEBOUNCE_CYCLES cycles.
REQ-018 If in is high while reset is released, deb starts at 0 and a rising pulse SHALL be emitted after the REQ-016 latency.

Reset
REQ-019 While reset is 0, all synchronizer flops, deb, cnt and out SHALL be 0 immediately, independent of clk.
REQ-020 Reset asserted mid-debounce SHALL abort the count; no pulse for that transition is emitted.
REQ-021 The first edge after reset deasserts SHALL behave as a normal sampling edge.

Structure
REQ-022 A shared package SHALL define the edge-mode enum (EDGE_RISE, EDGE_FALL, EDGE_BOTH) used by pulse and its users.
REQ-023 The synchronizer SHALL be a separate sub-module pulse_sync parameterised by SYNC_STAGES; debounce and edge logic stay in pulse.
REQ-024 Out-of-range parameters SHALL be rejected at elaboration.

Verification
REQ-025 Defaults; reset, then hold in=1 for 20 cycles -> out high exactly one cycle, 5 edges after first sampling edge; then 0.
REQ-026 Defaults; in=1 for 3 cycles then 0 -> out never asserts, deb stays 0.
REQ-027 EDGE_MODE=EDGE_BOTH; in 0->1, held 10 cycles, then 1->0 -> two one-cycle pulses, each at 5-edge latency.
REQ-028 Defaults; in=1, reset to 0 two cycles later -> out, deb and cnt go 0 asynchronously; in still 1 after release -> one pulse 5 edges after release.
REQ-029 DEBOUNCE_CYCLES=1, SYNC_STAGES=2; in toggles every 4 cycles -> one pulse per rising edge, latency 2.
REQ-030 Integration: drives the start control of the game_state FSM; one press of start -> exactly one state advance (START to PLAYING).

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and limits for the pulse debouncer and anything that configures it.
package pulse_pkg;

  // Which accepted transition of the debounced level produces an output pulse.
  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  localparam int unsigned MaxSyncStages     = 4;
  localparam int unsigned MaxDebounceCycles = 65535;

  // True when a debounced transition to new_level should be reported under mode.
  function automatic logic edge_match(edge_mode_e mode, logic new_level);
    case (mode)
      EDGE_RISE: return new_level;
      EDGE_FALL: return ~new_level;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/pulse_sync.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module pulse_sync
  import pulse_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (SYNC_STAGES < 1 || SYNC_STAGES > MaxSyncStages) begin : gen_bad_stages
    $error("pulse_sync: SYNC_STAGES must be in 1..4");
  end

  logic [SYNC_STAGES-1:0] sync_d, sync_q;

  // Shift the raw input one stage further down the chain every edge.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d_i;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Chain storage; cleared immediately on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pulse.sv
// Synchronize, debounce and edge-detect a raw level into a one-cycle pulse.
module pulse
  import pulse_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter edge_mode_e  EDGE_MODE       = EDGE_RISE
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > MaxDebounceCycles) begin : gen_bad_debounce
    $error("pulse: DEBOUNCE_CYCLES must be in 1..65535");
  end

  if (EDGE_MODE != EDGE_RISE && EDGE_MODE != EDGE_FALL && EDGE_MODE != EDGE_BOTH)
  begin : gen_bad_mode
    $error("pulse: EDGE_MODE is not a legal edge_mode_e value");
  end

  localparam int unsigned   CntW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            s;
  logic            deb_d, deb_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            out_d, out_q;

  pulse_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (in),
    .q_o   (s)
  );

  // Accept a new level only after it has differed from deb for DEBOUNCE_CYCLES edges;
  // the pulse is raised on the very edge the accepted level is loaded.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    out_d = 1'b0;
    if (s == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      deb_d = s;
      cnt_d = '0;
      out_d = edge_match(EDGE_MODE, s);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state and output pulse register; reset aborts any count in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pulse.sv
module tb_pulse;
  import pulse_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic in_a, in_b, in_c, in_d;
  logic out_a, out_b, out_c, out_d;

  int unsigned cyc = 0;
  int ncmp = 0;
  int nfail = 0;

  int unsigned qa[$];
  int unsigned qb[$];
  int unsigned qc[$];
  int unsigned qd[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // a: defaults; b: both edges; c: no debounce; d: falling, 3 stages, 3 cycles.
  pulse dut_a (.clk(clk), .reset(reset), .in(in_a), .out(out_a));

  pulse #(.EDGE_MODE(EDGE_BOTH)) dut_b (.clk(clk), .reset(reset), .in(in_b), .out(out_b));

  pulse #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut_c (
    .clk(clk), .reset(reset), .in(in_c), .out(out_c)
  );

  pulse #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(3), .EDGE_MODE(EDGE_FALL)) dut_d (
    .clk(clk), .reset(reset), .in(in_d), .out(out_d)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitors: every high out cycle must match the oldest expected pulse edge.
  always @(negedge clk) begin
    if (out_a) begin
      if (qa.size() == 0) check("a_spurious_pulse", {31'b0, out_a}, 32'd0);
      else check("a_pulse_edge", cyc, qa.pop_front());
    end
    if (out_b) begin
      if (qb.size() == 0) check("b_spurious_pulse", {31'b0, out_b}, 32'd0);
      else check("b_pulse_edge", cyc, qb.pop_front());
    end
    if (out_c) begin
      if (qc.size() == 0) check("c_spurious_pulse", {31'b0, out_c}, 32'd0);
      else check("c_pulse_edge", cyc, qc.pop_front());
    end
    if (out_d) begin
      if (qd.size() == 0) check("d_spurious_pulse", {31'b0, out_d}, 32'd0);
      else check("d_pulse_edge", cyc, qd.pop_front());
    end
  end

  initial begin
    reset = 1'b0;
    in_a = 1'b0; in_b = 1'b0; in_c = 1'b0; in_d = 1'b0;

    // Reset state, before and after clocks run.
    #1;
    check("rst_out_a", {31'b0, out_a}, 32'd0);
    check("rst_deb_a", {31'b0, dut_a.deb_q}, 32'd0);
    step(2);
    check("rst_outs_all", {28'b0, out_a, out_b, out_c, out_d}, 32'd0);
    check("rst_cnt_a", 32'(dut_a.cnt_q), 32'd0);
    reset = 1'b1;
    step(3);

    // Defaults: long press gives one pulse 5 edges after first sampling edge.
    in_a = 1'b1;
    qa.push_back(cyc + 6);
    step(20);
    check("a_deb_high", {31'b0, dut_a.deb_q}, 32'd1);
    in_a = 1'b0;
    step(10);
    check("a_deb_low", {31'b0, dut_a.deb_q}, 32'd0);

    // Glitch of 3 cycles is rejected.
    in_a = 1'b1;
    step(3);
    in_a = 1'b0;
    step(10);
    check("a_glitch_deb", {31'b0, dut_a.deb_q}, 32'd0);

    // Both edges: two pulses at 5-edge latency each.
    in_b = 1'b1;
    qb.push_back(cyc + 6);
    step(10);
    in_b = 1'b0;
    qb.push_back(cyc + 6);
    step(10);

    // Falling only, 3 stages + 3 cycles: latency 5, rising ignored.
    in_d = 1'b1;
    step(10);
    check("d_deb_high", {31'b0, dut_d.deb_q}, 32'd1);
    in_d = 1'b0;
    qd.push_back(cyc + 6);
    step(10);

    // No debounce: toggle every 4 cycles, one pulse per rise at latency 2.
    for (int i = 0; i < 6; i++) begin
      in_c = ~in_c;
      if (in_c) qc.push_back(cyc + 3);
      step(4);
    end
    step(5);

    // Reset mid-debounce aborts the count; press still held after release pulses once.
    in_a = 1'b1;
    step(4);
    check("a_cnt_mid", 32'(dut_a.cnt_q), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("async_out_a", {31'b0, out_a}, 32'd0);
    check("async_deb_a", {31'b0, dut_a.deb_q}, 32'd0);
    check("async_cnt_a", 32'(dut_a.cnt_q), 32'd0);
    check("async_sync_a", 32'(dut_a.u_sync.sync_q), 32'd0);
    step(3);
    check("held_cnt_a", 32'(dut_a.cnt_q), 32'd0);
    check("held_out_a", {31'b0, out_a}, 32'd0);
    reset = 1'b1;
    qa.push_back(cyc + 6);
    step(15);
    check("a_deb_after_rst", {31'b0, dut_a.deb_q}, 32'd1);

    // Every expected pulse must have been seen.
    check("a_missing", qa.size(), 32'd0);
    check("b_missing", qb.size(), 32'd0);
    check("c_missing", qc.size(), 32'd0);
    check("d_missing", qd.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
